ram_serial_loader: RTL and testbench

//  Upstream write master for the 32 KiB single-port program RAM. Takes a framed byte

---
 rtl/ram_serial_loader_pkg.sv | 24 ++
 rtl/ram_serial_loader_if.sv | 36 +++
 rtl/ram_serial_loader_byte_timeout.sv | 34 +++
 rtl/ram_serial_loader.sv | 146 ++++++++++++++
 tb/tb_ram_serial_loader.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_serial_loader_pkg.sv
// Shared definitions for the serial RAM loader.
//   - loader_state_t : FSM state encoding, also exported on the debug port
//   - ADDR_W / LEN_W : RAM address width (32 KiB) and frame length field width
//   - SYNC_BYTE_DEFAULT : default frame start marker
package ram_serial_loader_pkg;

    localparam int ADDR_W = 15;
    localparam int LEN_W  = 16;
    localparam int DATA_W = 8;

    localparam logic [DATA_W-1:0] SYNC_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        A_HI  = 3'd1,
        A_LO  = 3'd2,
        L_HI  = 3'd3,
        L_LO  = 3'd4,
        DATA  = 3'd5,
        WRITE = 3'd6,
        CSUM  = 3'd7
    } loader_state_t;

endpackage

// File: rtl/ram_serial_loader_if.sv
// Bus bundle between uart_rx, the loader and the RAM write port.
//   rx_valid/rx_data/rx_ready : byte stream from uart_rx
//   ram_we/ram_addr/ram_data  : RAM write port (sampled by the RAM on negedge)
//   cpu_hold/done/error       : CPU control and load status
//   dbg_state                 : current loader FSM state
//
// Handshake: a byte transfers on a posedge where rx_valid && rx_ready are both
// high. Once rx_valid is raised, rx_valid and rx_data stay stable until that
// transfer happens; rx_ready may drop at any time and does not depend on rx_valid.
interface ram_serial_loader_if;
    import ram_serial_loader_pkg::*;

    logic                rx_valid;
    logic [DATA_W-1:0]   rx_data;
    logic                rx_ready;
    logic                ram_we;
    logic [ADDR_W-1:0]   ram_addr;
    logic [DATA_W-1:0]   ram_data;
    logic                cpu_hold;
    logic                done;
    logic                error;
    loader_state_t       dbg_state;

    // Loader side
    modport master (
        input  rx_valid, rx_data,
        output rx_ready, ram_we, ram_addr, ram_data, cpu_hold, done, error, dbg_state
    );

    // Environment side (uart_rx source, RAM sink, CPU control)
    modport slave (
        output rx_valid, rx_data,
        input  rx_ready, ram_we, ram_addr, ram_data, cpu_hold, done, error, dbg_state
    );

endinterface

// File: rtl/ram_serial_loader_byte_timeout.sv
// Inter-byte watchdog for the loader.
//   clk, reset_n : clock, asynchronous active-low reset
//   i_clear      : restart the count (a byte was accepted)
//   i_enable     : count while high, hold at zero while low
//   o_expired    : high once TIMEOUT_CYCLES cycles passed without a clear
module byte_timeout #(
    parameter int TIMEOUT_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int                CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_clear || !i_enable) begin
            r_count <= '0;
        end else if (r_count != LIMIT) begin
            // Saturate so o_expired stays up until the FSM reacts.
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_expired = (r_count == LIMIT);

endmodule

// File: rtl/ram_serial_loader.sv
// Serial program loader: parses SYNC, ADDR_HI, ADDR_LO, LEN_HI, LEN_LO,
// LEN data bytes, CSUM from uart_rx and writes the payload into the 32 KiB RAM.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (master) : byte stream in, RAM write port, cpu_hold/done/error, debug state
module ram_serial_loader
    import ram_serial_loader_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 500000,
    parameter bit         HOLD_AT_RESET  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    ram_serial_loader_if.master   bus
);

    loader_state_t       r_state;
    loader_state_t       w_next_state;
    logic [ADDR_W-1:0]   r_ptr;
    logic [LEN_W-1:0]    r_remaining;
    logic [DATA_W-1:0]   r_csum;
    logic [ADDR_W-1:0]   r_ram_addr;
    logic [DATA_W-1:0]   r_ram_data;
    logic                r_cpu_hold;
    logic                r_done;
    logic                r_error;

    logic                w_rx_ready;
    logic                w_accept;
    logic                w_expired;
    logic                w_timer_enable;
    logic                w_timeout_abort;
    logic                w_len_zero;

    assign w_rx_ready      = (r_state != WRITE);
    assign w_accept        = bus.rx_valid && w_rx_ready;
    assign w_timer_enable  = (r_state != IDLE);
    // A byte arriving on the expiry cycle still counts; the frame is alive.
    assign w_timeout_abort = w_timer_enable && w_expired && !w_accept;
    assign w_len_zero      = ({r_remaining[LEN_W-1:8], bus.rx_data} == '0);

    byte_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_clear   (w_accept),
        .i_enable  (w_timer_enable),
        .o_expired (w_expired)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:  if (w_accept && bus.rx_data == SYNC_BYTE) w_next_state = A_HI;
            A_HI:  if (w_accept) w_next_state = A_LO;
            A_LO:  if (w_accept) w_next_state = L_HI;
            L_HI:  if (w_accept) w_next_state = L_LO;
            L_LO:  if (w_accept) w_next_state = w_len_zero ? CSUM : DATA;
            DATA:  if (w_accept) w_next_state = WRITE;
            WRITE: w_next_state = (r_remaining == LEN_W'(1)) ? CSUM : DATA;
            CSUM:  if (w_accept) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
        if (w_timeout_abort) begin
            w_next_state = IDLE;
        end
    end

    // Datapath and status registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr       <= '0;
            r_remaining <= '0;
            r_csum      <= '0;
            r_ram_addr  <= '0;
            r_ram_data  <= '0;
            r_cpu_hold  <= HOLD_AT_RESET;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_timeout_abort) begin
                r_error <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (w_accept && bus.rx_data == SYNC_BYTE) begin
                        r_error    <= 1'b0;
                        r_csum     <= '0;
                        r_cpu_hold <= 1'b1;
                    end
                end
                // Bit 7 of ADDR_HI is dropped: the RAM is only 32 KiB.
                A_HI: if (w_accept) r_ptr[ADDR_W-1:8] <= bus.rx_data[6:0];
                A_LO: if (w_accept) r_ptr[7:0] <= bus.rx_data;
                L_HI: if (w_accept) r_remaining[LEN_W-1:8] <= bus.rx_data;
                L_LO: if (w_accept) r_remaining[7:0] <= bus.rx_data;
                DATA: begin
                    if (w_accept) begin
                        r_ram_addr <= r_ptr;
                        r_ram_data <= bus.rx_data;
                        r_csum     <= r_csum + bus.rx_data;
                    end
                end
                WRITE: begin
                    // 15-bit pointer wraps 7FFF -> 0000 on its own.
                    r_ptr       <= r_ptr + ADDR_W'(1);
                    r_remaining <= r_remaining - LEN_W'(1);
                end
                CSUM: begin
                    if (w_accept) begin
                        if (bus.rx_data == r_csum) begin
                            r_done     <= 1'b1;
                            r_cpu_hold <= 1'b0;
                        end else begin
                            r_error <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.rx_ready  = w_rx_ready;
    // Write strobe decoded from the state register so a reset kills it at once.
    assign bus.ram_we    = (r_state == WRITE);
    assign bus.ram_addr  = r_ram_addr;
    assign bus.ram_data  = r_ram_data;
    assign bus.cpu_hold  = r_cpu_hold;
    assign bus.done      = r_done;
    assign bus.error     = r_error;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_ram_serial_loader.sv
module tb_ram_serial_loader;
  import ram_serial_loader_pkg::*;

  localparam int TIMEOUT = 100;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ram_serial_loader_if bus();

  ram_serial_loader #(
    .SYNC_BYTE      (8'hA5),
    .TIMEOUT_CYCLES (TIMEOUT),
    .HOLD_AT_RESET  (1'b1)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [22:0] exp_q[$];
  logic [22:0] act_q[$];
  logic [7:0]  payload[$];
  logic [7:0]  exp_mem [0:32767];
  logic [7:0]  act_mem [0:32767];
  int done_cnt   = 0;
  int ready_viol = 0;
  int stall_cnt  = 0;

  // RAM samples the write port on negedge; the loader status is observed there too.
  always @(negedge clk) begin
    if (bus.ram_we === 1'b1) begin
      act_q.push_back({bus.ram_addr, bus.ram_data});
      act_mem[bus.ram_addr] = bus.ram_data;
    end
    if (bus.done === 1'b1) done_cnt++;
    if (bus.rx_ready === bus.ram_we) ready_viol++;
    if (bus.rx_valid === 1'b1 && bus.rx_ready === 1'b0) stall_cnt++;
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_write(input logic [14:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
    exp_mem[a] = d;
  endtask

  // Called and returns at posedge+1. Leaves rx_valid high for back-to-back use.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int guard;
    if (gap > 0) begin
      bus.rx_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    guard = 0;
    while (bus.rx_ready !== 1'b1 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (bus.rx_ready !== 1'b1) check("rx_ready_stuck", 32'(bus.rx_ready), 32'd1);
    @(posedge clk); #1;
  endtask

  function automatic int pick_gap(input int gap_max);
    return (gap_max == 0) ? 0 : int'($urandom_range(0, gap_max));
  endfunction

  task automatic check_writes(input string tag);
    check({tag, "_nwrites"}, 32'(act_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < act_q.size())
        check($sformatf("%s_wr%0d", tag, i), 32'(act_q[i]), 32'(exp_q[i]));
    end
  endtask

  // Full frame from the global payload; expectations come from the frame rules.
  task automatic run_frame(input logic [7:0] ahi, input logic [7:0] alo, input bit bad,
                           input int gap_max, input bit garbage, input string tag);
    logic [14:0] a;
    logic [7:0]  cs;
    logic [15:0] len;
    exp_q.delete();
    act_q.delete();
    done_cnt = 0;
    len = 16'(payload.size());
    a   = {ahi[6:0], alo};
    cs  = 8'h00;
    foreach (payload[i]) begin
      model_write(a, payload[i]);
      cs = cs + payload[i];
      a  = a + 15'd1;
    end
    if (bad) cs = cs + 8'h01;
    if (garbage) begin
      send_byte(8'h00, 0);
      send_byte(8'hFF, 0);
      send_byte(8'h12, 0);
      bus.rx_valid = 1'b0;
      tick(1);
      check({tag, "_garbage_state"}, 32'(bus.dbg_state), 32'(IDLE));
      check({tag, "_garbage_hold"}, 32'(bus.cpu_hold), 32'd0);
    end
    send_byte(8'hA5, pick_gap(gap_max));
    send_byte(ahi, pick_gap(gap_max));
    send_byte(alo, pick_gap(gap_max));
    send_byte(len[15:8], pick_gap(gap_max));
    send_byte(len[7:0], pick_gap(gap_max));
    foreach (payload[i]) send_byte(payload[i], pick_gap(gap_max));
    send_byte(cs, pick_gap(gap_max));
    bus.rx_valid = 1'b0;
    tick(3);
    check_writes(tag);
    check({tag, "_done"}, 32'(done_cnt), bad ? 32'd0 : 32'd1);
    check({tag, "_error"}, 32'(bus.error), 32'(bad));
    check({tag, "_hold"}, 32'(bus.cpu_hold), 32'(bad));
    check({tag, "_state"}, 32'(bus.dbg_state), 32'(IDLE));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int mism;
    for (int i = 0; i < 32768; i++) begin
      exp_mem[i] = 8'h00;
      act_mem[i] = 8'h00;
    end
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    reset_n = 1'b0;
    tick(3);

    // Reset state
    check("rst_rx_ready", 32'(bus.rx_ready), 32'd1);
    check("rst_ram_we",   32'(bus.ram_we),   32'd0);
    check("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
    check("rst_ram_data", 32'(bus.ram_data), 32'd0);
    check("rst_cpu_hold", 32'(bus.cpu_hold), 32'd1);
    check("rst_done",     32'(bus.done),     32'd0);
    check("rst_error",    32'(bus.error),    32'd0);
    check("rst_state",    32'(bus.dbg_state), 32'(IDLE));
    reset_n = 1'b1;
    tick(2);

    // 1: basic frame
    payload = '{8'h11, 8'h22, 8'h33};
    run_frame(8'h01, 8'h00, 1'b0, 1, 1'b0, "t1");

    // 2: bad checksum, then a good frame clears error
    run_frame(8'h01, 8'h00, 1'b1, 1, 1'b0, "t2_bad");
    run_frame(8'h01, 8'h00, 1'b0, 0, 1'b0, "t2_good");

    // 3: address wrap, bit 7 of ADDR_HI ignored
    payload = '{8'hAA, 8'hBB};
    run_frame(8'h7F, 8'hFF, 1'b0, 1, 1'b0, "t3_wrap");
    run_frame(8'hFF, 8'hFF, 1'b0, 2, 1'b0, "t3_bit7");

    // 4: zero length frame preceded by garbage
    payload.delete();
    run_frame(8'h00, 8'h10, 1'b0, 1, 1'b1, "t4_len0");

    // 5a: timeout after the 2nd of 4 data bytes
    exp_q.delete();
    act_q.delete();
    done_cnt = 0;
    model_write(15'h0200, 8'h01);
    model_write(15'h0201, 8'h02);
    send_byte(8'hA5, 0);
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h04, 0);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    bus.rx_valid = 1'b0;
    tick(TIMEOUT - 5);
    check("t5_early_error", 32'(bus.error), 32'd0);
    tick(15);
    check("t5_error", 32'(bus.error), 32'd1);
    check("t5_state", 32'(bus.dbg_state), 32'(IDLE));
    check("t5_hold",  32'(bus.cpu_hold), 32'd1);
    check("t5_done",  32'(done_cnt), 32'd0);
    check_writes("t5_to");

    // 5b: reset mid-DATA, rx_valid asserted during reset is ignored
    exp_q.delete();
    act_q.delete();
    done_cnt = 0;
    model_write(15'h0300, 8'hC1);
    model_write(15'h0301, 8'hC2);
    model_write(15'h0302, 8'hC3);
    send_byte(8'hA5, 0);
    send_byte(8'h03, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h05, 0);
    send_byte(8'hC1, 0);
    send_byte(8'hC2, 0);
    send_byte(8'hC3, 0);
    bus.rx_valid = 1'b0;
    tick(1);
    check("t5r_pre_state", 32'(bus.dbg_state), 32'(DATA));
    bus.rx_data  = 8'hA5;
    bus.rx_valid = 1'b1;
    reset_n = 1'b0;
    #1;
    check("t5r_we_now", 32'(bus.ram_we), 32'd0);
    tick(20);
    check("t5r_state",    32'(bus.dbg_state), 32'(IDLE));
    check("t5r_rx_ready", 32'(bus.rx_ready), 32'd1);
    check("t5r_addr",     32'(bus.ram_addr), 32'd0);
    check("t5r_data",     32'(bus.ram_data), 32'd0);
    check("t5r_hold",     32'(bus.cpu_hold), 32'd1);
    check("t5r_error",    32'(bus.error), 32'd0);
    bus.rx_valid = 1'b0;
    reset_n = 1'b1;
    tick(5);
    check("t5r_post_state", 32'(bus.dbg_state), 32'(IDLE));
    check_writes("t5r");

    // 6: back-to-back bytes, each data byte stalls exactly once in WRITE
    payload.delete();
    for (int i = 0; i < 8; i++) payload.push_back(8'($urandom_range(0, 255)));
    stall_cnt = 0;
    run_frame(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0, 0, 1'b0, "t6_b2b");
    check("t6_stalls", 32'(stall_cnt), 32'd8);

    // Random frames
    for (int f = 0; f < 10; f++) begin
      logic [7:0] ahi;
      logic [7:0] alo;
      bit bad;
      int len;
      len = int'($urandom_range(0, 24));
      payload.delete();
      for (int i = 0; i < len; i++) payload.push_back(8'($urandom_range(0, 255)));
      ahi = (f % 3 == 0) ? 8'h7F : 8'($urandom_range(0, 255));
      alo = (f % 3 == 0) ? 8'($urandom_range(8'hF0, 8'hFF)) : 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 3) == 0);
      run_frame(ahi, alo, bad, int'($urandom_range(0, 2)), 1'b0, $sformatf("rnd%0d", f));
    end

    // RAM image vs model
    mism = 0;
    for (int i = 0; i < 32768; i++) if (act_mem[i] !== exp_mem[i]) mism++;
    check("mem_scoreboard", 32'(mism), 32'd0);
    check("ready_vs_we", 32'(ready_viol), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard stop in case a handshake wedges the sequence.
  initial begin
    #2000000;
    $display("FAIL global_timeout: sequence did not complete");
    $fatal(1, "global timeout");
  end

endmodule
